// File: rtl/instr_fetch_responder_pkg.sv
// rtl/instr_fetch_responder_pkg.sv - shared types and constants for the fetch responder
package instr_fetch_responder_pkg;

  // Fetch FSM encoding; FAULT is absorbing until reset.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_FAULT = 2'd2
  } fetch_state_t;

  // Branch target source selected by the control unit.
  localparam logic PCSEL_REL = 1'b0;
  localparam logic PCSEL_ABS = 1'b1;

  // Width of the branch immediate carried in k[25:0].
  localparam int K_IMM_W = 26;

  // Instruction word and timeout counter widths.
  localparam int INSTR_W = 32;
  localparam int CNT_W   = 4;

endpackage

// File: rtl/instr_fetch_responder_if.sv
// rtl/instr_fetch_responder_if.sv - instruction memory req/ack bus
interface instr_fetch_responder_if #(
  parameter int ADDR_W = 64
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ack;
  logic [31:0]       mem_rdata;

  // Responder side: issues requests, receives the instruction word.
  modport master (
    output mem_req,
    output mem_addr,
    input  mem_ack,
    input  mem_rdata
  );

  // Memory side: sees requests, returns ack and data.
  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_ack,
    output mem_rdata
  );

endinterface

// File: rtl/instr_fetch_responder_branch_target_calc.sv
// rtl/instr_fetch_responder_branch_target_calc.sv - relative/absolute branch target mux and adder
module instr_fetch_responder_branch_target_calc
  import instr_fetch_responder_pkg::*;
#(
  parameter int ADDR_W = 64
) (
  input  logic [ADDR_W-1:0]  fetch_pc,
  input  logic [INSTR_W-1:0] k,
  input  logic [ADDR_W-1:0]  reg_in,
  input  logic               pc_sel,
  output logic [ADDR_W-1:0]  target
);

  logic [K_IMM_W-1:0] imm;
  logic [ADDR_W-1:0]  imm_ext;
  logic [ADDR_W-1:0]  rel_off;
  logic               unused_k_hi;

  // Upper k bits carry opcode fields that do not contribute to the target.
  assign unused_k_hi = ^k[INSTR_W-1:K_IMM_W];

  // Word offset: sign-extend the immediate, then scale by 4; the sum wraps naturally.
  always_comb begin
    imm     = k[K_IMM_W-1:0];
    imm_ext = {{(ADDR_W-K_IMM_W){imm[K_IMM_W-1]}}, imm};
    rel_off = {imm_ext[ADDR_W-3:0], 2'b00};
    target  = (pc_sel == PCSEL_ABS) ? reg_in : (fetch_pc + rel_off);
  end

endmodule

// File: rtl/instr_fetch_responder.sv
// rtl/instr_fetch_responder.sv - fetch-side responder owning PC and IR for the control unit
module instr_fetch_responder
  import instr_fetch_responder_pkg::*;
#(
  parameter int                ADDR_W   = 64,
  parameter int                TIMEOUT  = 15,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   fetch_req,
  input  logic                   pc_load,
  input  logic                   pc_sel,
  input  logic [INSTR_W-1:0]     k,
  input  logic [ADDR_W-1:0]      reg_in,
  instr_fetch_responder_if.master mem_bus,
  output logic [INSTR_W-1:0]     IR,
  output logic                   ir_valid,
  output logic [ADDR_W-1:0]      pc,
  output logic [ADDR_W-1:0]      fetch_pc,
  output logic                   busy,
  output logic                   fault
);

  // Last count value still allowed to wait for an ack.
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  fetch_state_t state_q, state_n;

  logic [ADDR_W-1:0]  pc_q;
  logic [ADDR_W-1:0]  fetch_pc_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [INSTR_W-1:0] ir_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               mem_req_q;
  logic               ir_valid_q;
  logic               fault_q;

  logic               do_load;
  logic               do_issue;
  logic               do_ack;
  logic               do_fault;
  logic               cnt_inc;
  logic [ADDR_W-1:0]  target;

  instr_fetch_responder_branch_target_calc #(
    .ADDR_W (ADDR_W)
  ) u_target (
    .fetch_pc (fetch_pc_q),
    .k        (k),
    .reg_in   (reg_in),
    .pc_sel   (pc_sel),
    .target   (target)
  );

  // State register; reset drops any outstanding request by returning to IDLE.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_n;
    end
  end

  // Next-state and action decode; pc_load wins over fetch_req so fetches see the new PC.
  always_comb begin
    state_n  = state_q;
    do_load  = 1'b0;
    do_issue = 1'b0;
    do_ack   = 1'b0;
    do_fault = 1'b0;
    cnt_inc  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (pc_load) begin
          do_load = 1'b1;
        end else if (fetch_req) begin
          if (pc_q[1:0] == 2'b00) begin
            do_issue = 1'b1;
            state_n  = ST_REQ;
          end else begin
            do_fault = 1'b1;
            state_n  = ST_FAULT;
          end
        end
      end
      ST_REQ: begin
        if (mem_bus.mem_ack) begin
          do_ack  = 1'b1;
          state_n = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          do_fault = 1'b1;
          state_n  = ST_FAULT;
        end else begin
          cnt_inc = 1'b1;
        end
      end
      ST_FAULT: begin
        state_n = ST_FAULT;
      end
      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  // PC, IR, memory request and fault registers driven by the decoded actions.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      fetch_pc_q <= '0;
      ir_q       <= '0;
      mem_req_q  <= 1'b0;
      mem_addr_q <= '0;
      ir_valid_q <= 1'b0;
      fault_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ir_valid_q <= do_ack;
      if (do_load) begin
        pc_q <= target;
      end
      if (do_issue) begin
        mem_addr_q <= pc_q;
        mem_req_q  <= 1'b1;
        cnt_q      <= '0;
      end
      if (cnt_inc) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (do_ack) begin
        ir_q       <= mem_bus.mem_rdata;
        fetch_pc_q <= mem_addr_q;
        pc_q       <= mem_addr_q + ADDR_W'(4);
        mem_req_q  <= 1'b0;
      end
      if (do_fault) begin
        fault_q   <= 1'b1;
        mem_req_q <= 1'b0;
      end
    end
  end

  assign mem_bus.mem_req  = mem_req_q;
  assign mem_bus.mem_addr = mem_addr_q;
  assign IR               = ir_q;
  assign ir_valid         = ir_valid_q;
  assign pc               = pc_q;
  assign fetch_pc         = fetch_pc_q;
  assign fault            = fault_q;
  assign busy             = (state_q == ST_REQ);

endmodule

// File: tb/tb_instr_fetch_responder.sv
// tb/tb_instr_fetch_responder.sv - scoreboard bench for instr_fetch_responder
module tb_instr_fetch_responder;

  typedef struct {
    logic [31:0] ir;
    logic [63:0] fpc;
    logic [63:0] pc;
  } exp_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        fetch_req = 1'b0;
  logic        pc_load = 1'b0;
  logic        pc_sel = 1'b0;
  logic [31:0] k = '0;
  logic [63:0] reg_in = '0;
  logic [31:0] IR;
  logic        ir_valid;
  logic [63:0] pc;
  logic [63:0] fetch_pc;
  logic        busy;
  logic        fault;

  int n_checks = 0;
  int n_fail = 0;

  exp_t        exp_q[$];
  logic [63:0] model_pc = '0;
  logic [63:0] model_fpc = '0;
  logic [63:0] exp_addr = '0;
  int          req_cycles = 0;
  int          busy_cycles = 0;
  int          valid_cnt = 0;
  int          wait_cfg = 0;
  int          wait_cnt = 0;
  bit          mem_en = 1'b0;
  bit          ack_sent = 1'b0;
  bit          stale_ack = 1'b0;

  instr_fetch_responder_if #(.ADDR_W(64)) mif ();

  instr_fetch_responder #(
    .ADDR_W   (64),
    .TIMEOUT  (15),
    .RESET_PC (64'h0)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .fetch_req (fetch_req),
    .pc_load   (pc_load),
    .pc_sel    (pc_sel),
    .k         (k),
    .reg_in    (reg_in),
    .mem_bus   (mif),
    .IR        (IR),
    .ir_valid  (ir_valid),
    .pc        (pc),
    .fetch_pc  (fetch_pc),
    .busy      (busy),
    .fault     (fault)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [63:0] addr);
    return 32'h8B020020 ^ addr[31:0];
  endfunction

  // Memory model: answers after wait_cfg wait cycles, or a stale ack when asked.
  always @(negedge clock) begin
    mif.mem_ack = 1'b0;
    if (stale_ack) begin
      mif.mem_ack   = 1'b1;
      mif.mem_rdata = 32'hDEADBEEF;
    end else if (mem_en && mif.mem_req && !ack_sent) begin
      if (wait_cnt == wait_cfg) begin
        mif.mem_ack   = 1'b1;
        mif.mem_rdata = mem_word(mif.mem_addr);
        ack_sent      = 1'b1;
      end else begin
        wait_cnt++;
      end
    end
    if (!mif.mem_req) begin
      ack_sent = 1'b0;
      wait_cnt = 0;
    end
  end

  // Output monitor: scoreboard pop on ir_valid, address stability while requesting.
  always @(negedge clock) begin
    exp_t e;
    if (!reset) begin
      if (mif.mem_req) begin
        req_cycles++;
        check("mem_addr", mif.mem_addr, exp_addr);
      end
      if (busy) busy_cycles++;
      if (ir_valid) begin
        valid_cnt++;
        if (exp_q.size() == 0) begin
          check("ir_valid_unexpected", 64'(ir_valid), 64'(0));
        end else begin
          e = exp_q.pop_front();
          check("IR", 64'(IR), 64'(e.ir));
          check("fetch_pc", fetch_pc, e.fpc);
          check("pc_after_fetch", pc, e.pc);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    stale_ack = 1'b0;
    repeat (2) tick();
    reset = 1'b0;
    model_pc = '0;
    model_fpc = '0;
  endtask

  task automatic do_fetch(input int waits);
    exp_t e;
    int n;
    wait_cfg = waits;
    mem_en = 1'b1;
    exp_addr = model_pc;
    e.ir = mem_word(model_pc);
    e.fpc = model_pc;
    e.pc = model_pc + 64'd4;
    exp_q.push_back(e);
    req_cycles = 0;
    busy_cycles = 0;
    valid_cnt = 0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n = 0;
    while (valid_cnt == 0 && n < 40) begin
      tick();
      n++;
    end
    check("fetch_done", 64'(valid_cnt != 0), 64'(1));
    tick();
    check("ir_valid_pulses", 64'(valid_cnt), 64'(1));
    check("req_cycles", 64'(req_cycles), 64'(waits + 1));
    check("busy_cycles", 64'(busy_cycles), 64'(waits + 1));
    model_fpc = model_pc;
    model_pc = model_pc + 64'd4;
  endtask

  task automatic do_load(input bit sel, input logic [31:0] kk, input logic [63:0] rv, input bit with_fetch);
    logic [63:0] ext;
    ext = {{38{kk[25]}}, kk[25:0]};
    pc_sel = sel;
    k = kk;
    reg_in = rv;
    pc_load = 1'b1;
    fetch_req = with_fetch;
    tick();
    pc_load = 1'b0;
    fetch_req = 1'b0;
    model_pc = sel ? rv : (model_fpc + (ext << 2));
    check("pc_after_load", pc, model_pc);
    check("no_req_on_load", 64'(mif.mem_req), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int n;
    mif.mem_ack = 1'b0;
    mif.mem_rdata = '0;
    do_reset();

    check("rst_pc", pc, 64'h0);
    check("rst_fetch_pc", fetch_pc, 64'h0);
    check("rst_IR", 64'(IR), 64'h0);
    check("rst_mem_req", 64'(mif.mem_req), 64'(0));
    check("rst_mem_addr", mif.mem_addr, 64'h0);
    check("rst_ir_valid", 64'(ir_valid), 64'(0));
    check("rst_fault", 64'(fault), 64'(0));
    check("rst_busy", 64'(busy), 64'(0));

    do_fetch(0);
    do_fetch(5);

    do_load(1'b1, 32'h0, 64'h40, 1'b0);
    do_fetch(2);
    do_load(1'b0, 32'h03FFFFFE, 64'h0, 1'b0);
    check("rel_target", pc, 64'h38);
    do_load(1'b1, 32'h0, 64'h100, 1'b0);

    do_load(1'b1, 32'h0, 64'h200, 1'b1);
    do_fetch(1);

    for (int i = 0; i < 3; i++) do_fetch(int'($urandom_range(0, 3)));

    do_load(1'b1, 32'h0, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    do_fetch(0);
    check("pc_wrap", pc, 64'h0);
    do_load(1'b0, 32'hFC00_0001, 64'h0, 1'b0);

    mem_en = 1'b0;
    exp_addr = model_pc;
    req_cycles = 0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    n = 0;
    while (!fault && n < 40) begin
      tick();
      n++;
    end
    check("timeout_fault", 64'(fault), 64'(1));
    check("timeout_req_cycles", 64'(req_cycles), 64'(15));
    check("timeout_mem_req_low", 64'(mif.mem_req), 64'(0));
    check("timeout_busy_low", 64'(busy), 64'(0));
    fetch_req = 1'b1;
    repeat (3) tick();
    fetch_req = 1'b0;
    check("fault_ignores_fetch", 64'(req_cycles), 64'(15));
    check("fault_pc_hold", pc, model_pc);
    check("fault_sticky", 64'(fault), 64'(1));
    do_reset();
    check("reset_clears_fault", 64'(fault), 64'(0));
    check("reset_pc", pc, 64'h0);

    do_load(1'b1, 32'h0, 64'h102, 1'b0);
    req_cycles = 0;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    check("misalign_fault", 64'(fault), 64'(1));
    repeat (3) tick();
    check("misalign_no_req", 64'(req_cycles), 64'(0));
    check("misalign_pc_hold", pc, 64'h102);
    do_reset();

    mem_en = 1'b0;
    exp_addr = model_pc;
    fetch_req = 1'b1;
    tick();
    fetch_req = 1'b0;
    repeat (2) tick();
    check("stale_busy_before_reset", 64'(busy), 64'(1));
    reset = 1'b1;
    tick();
    reset = 1'b0;
    valid_cnt = 0;
    stale_ack = 1'b1;
    repeat (3) tick();
    stale_ack = 1'b0;
    tick();
    check("stale_IR", 64'(IR), 64'h0);
    check("stale_ir_valid", 64'(valid_cnt), 64'(0));
    check("stale_mem_req", 64'(mif.mem_req), 64'(0));
    check("stale_busy", 64'(busy), 64'(0));
    check("stale_scoreboard_empty", 64'(exp_q.size()), 64'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch_responder.md
Name: instr_fetch_responder

Overview:
- Fetch-side responder to the multi-cycle control unit.
- The control unit raises fetch_req in its instruction-fetch state. This block drives a variable-latency instruction memory over a req/ack handshake, captures the 32-bit instruction into IR, and returns ir_valid.
- It owns PC: post-increments by 4 on each completed fetch, and applies relative or absolute branch loads commanded by the control unit using its k constant or a register value.

Parameters:
- ADDR_W, 64, PC and memory address width.
- TIMEOUT, 15, maximum cycles to wait for mem_ack before fault (4-bit counter, 1..15).
- RESET_PC, 0, PC value after reset; must be word-aligned.

Ports:
- clock  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high.
- fetch_req  in  1  level request from control unit; sampled only in IDLE.
- pc_load  in  1  one-cycle branch strobe; honoured only in IDLE.
- pc_sel  in  1  0 = relative (fetch_pc + sext(k[25:0])<<2), 1 = absolute (reg_in).
- k  in  32  constant from control unit constant generator.
- reg_in  in  ADDR_W  register-file operand for absolute branch.
- mem_req  out  1  memory request.
- mem_addr  out  ADDR_W  request address; stable while mem_req is high.
- mem_ack  in  1  one-cycle acknowledge; mem_rdata valid in the same cycle.
- mem_rdata  in  32  instruction word.
- IR  out  32  instruction register.
- ir_valid  out  1  one-cycle pulse when IR is updated.
- pc  out  ADDR_W  current PC.
- fetch_pc  out  ADDR_W  address of the instruction currently in IR.
- busy  out  1  high in REQ state.
- fault  out  1  sticky; set on timeout or misaligned PC.

Behaviour:
- Reset values: state IDLE, pc = RESET_PC, fetch_pc = 0, IR = 0, mem_req = 0, mem_addr = 0, ir_valid = 0, fault = 0, timeout counter = 0. Reset aborts any outstanding request immediately; a late mem_ack after reset is ignored.
- States: IDLE, REQ, FAULT.
- IDLE:
  - pc_load high: pc <= target; stay in IDLE. A fetch_req in the same cycle is ignored, so fetches use the new PC.
  - Otherwise fetch_req high and pc[1:0] == 0: mem_addr <= pc, mem_req <= 1, counter <= 0, go to REQ.
  - Otherwise fetch_req high and pc[1:0] != 0: fault <= 1, go to FAULT; no memory request is issued.
- REQ:
  - mem_req is held high and mem_addr is held stable.
  - On mem_ack: IR <= mem_rdata; fetch_pc <= mem_addr; pc <= mem_addr + 4; mem_req <= 0; ir_valid pulses for 1 cycle; return to IDLE.
  - No ack: counter increments. When counter reaches TIMEOUT-1 without ack, mem_req <= 0, fault <= 1, go to FAULT.
  - pc_load and fetch_req are ignored in REQ.
- Latency: ir_valid rises in the cycle after mem_ack is sampled. Minimum total latency is 2 cycles (fetch_req to ir_valid) with zero-wait memory.
- FAULT: absorbing. IR and PC hold; fault stays high; exit only via reset.
- Relative target arithmetic:
  - Sign-extend k[25:0] to ADDR_W, shift left 2, add to fetch_pc.
  - Modulo 2^ADDR_W wrap, no overflow flag.
- Absolute target: reg_in unmodified. Misalignment is detected only at the next fetch.
- PC+4 wraps modulo 2^ADDR_W.
- busy = (state == REQ).

Decomposition:
- Shared package:
  - state encoding (IDLE = 2'd0, REQ = 2'd1, FAULT = 2'd2)
  - pc_sel encodings (PCSEL_REL = 1'b0, PCSEL_ABS = 1'b1)
  - the k field slice constant (26-bit branch immediate)
- One natural sub-module, branch_target_calc: combinational target mux/adder taking fetch_pc, k, reg_in, pc_sel and producing the target.
- FSM, counter and registers stay in the top module.

Test Plan:
- Reset then fetch_req with a 0-wait memory returning 0x8B020020 at address 0 -> mem_req for 1 cycle at mem_addr 0; IR = 0x8B020020; ir_valid one pulse; pc = 4; fetch_pc = 0.
- Memory acks after 5 wait cycles -> mem_addr stable at 4 throughout; busy high for 6 cycles; IR captured on the ack cycle; pc = 8.
- After a fetch at 0x40, pc_load with pc_sel = 0 and k[25:0] = 0x3FFFFFE (-2) -> pc = 0x38. Then pc_sel = 1 with reg_in = 0x100 -> pc = 0x100.
- pc_load and fetch_req asserted in the same IDLE cycle with reg_in = 0x200 -> no request that cycle; the next fetch_req issues mem_addr 0x200.
- No ack for TIMEOUT cycles -> mem_req drops; fault = 1; state FAULT; later fetch_req is ignored; reset clears fault and pc = RESET_PC.
- Absolute load to 0x102 then fetch_req -> fault = 1 with no mem_req ever asserted. Separately, reset asserted mid-REQ followed by a stale mem_ack -> IR stays 0 and ir_valid stays low.
